// File: rtl/barrel_pkg.sv
// Shared types and constants for barrel_normalizer and its search stage.
package barrel_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    // Stage k of the log-step search moves the word by 2^k bits.
    function automatic logic [31:0] stepOf(input logic [31:0] k);
        return 32'd1 << k;
    endfunction

endpackage

// File: rtl/barrel_normalizer_norm_step.sv
// One combinational stage of the normalizing search: shift by i_step if the top bits allow it.
module norm_step #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_sgn,
    input  logic [AMT_W-1:0]  i_step,
    output logic [DATA_W-1:0] o_word,
    output logic              o_take
);

    logic [DATA_W-1:0] w_topMask;
    logic [DATA_W-1:0] w_probe;

    // In signed mode the probe holds adjacent-bit differences, so s clear probe bits mean s+1 equal sign bits.
    assign w_topMask = ~({DATA_W{1'b1}} >> i_step);
    assign w_probe   = i_sgn ? (i_word ^ (i_word << 1)) : i_word;
    assign o_take    = (w_probe & w_topMask) == '0;
    assign o_word    = o_take ? (i_word << i_step) : i_word;

endmodule

// File: rtl/barrel_normalizer.sv
// Multi-cycle normalizer: recovers the left-shift distance of a word, one search stage per clock.
// Define BARREL_NORMALIZER_CHECK_EN to add the CHK_ERR reverse-shift self-check output.
module barrel_normalizer
    import barrel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    localparam int AMT_W = $clog2(DATA_W)
) (
    input  logic              Clk_s,
    input  logic              Rst_n,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              SGN,
    input  logic [DATA_W-1:0] D_IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] D_OUT,
    output logic [AMT_W-1:0]  SH_AMT,
    output logic              ZERO
`ifdef BARREL_NORMALIZER_CHECK_EN
    ,
    output logic              CHK_ERR
`endif
);

    state_t            r_state;
    logic [AMT_W-1:0]  r_k;
    logic [DATA_W-1:0] r_word;
    logic [AMT_W-1:0]  r_amt;
    logic              r_sgn;
    logic              r_inReady;
    logic              r_outValid;
    logic [DATA_W-1:0] r_dOut;
    logic [AMT_W-1:0]  r_shAmt;
    logic              r_zero;

    logic [DATA_W-1:0] w_stepWord;
    logic              w_take;
    logic [AMT_W-1:0]  w_step;
    logic              w_isZero;

    assign w_step = AMT_W'(stepOf(32'(r_k)));

    // A non-zero word never shifts to zero, so the working word alone tells us the input was zero.
    assign w_isZero = (r_word == '0);

    norm_step #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_normStep (
        .i_word (r_word),
        .i_sgn  (r_sgn),
        .i_step (w_step),
        .o_word (w_stepWord),
        .o_take (w_take)
    );

    // DONE spends its first cycle loading the result registers, giving a fixed AMT_W+1 latency.
    always_ff @(posedge Clk_s) begin
        if (!Rst_n) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_word     <= '0;
            r_amt      <= '0;
            r_sgn      <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_dOut     <= '0;
            r_shAmt    <= '0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_word    <= D_IN;
                        r_sgn     <= SGN;
                        r_amt     <= '0;
                        r_k       <= AMT_W'(AMT_W - 1);
                        r_inReady <= 1'b0;
                        r_state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    r_word <= w_stepWord;
                    if (w_take) begin
                        r_amt <= r_amt + w_step;
                    end
                    if (r_k == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k - AMT_W'(1);
                    end
                end
                DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                        r_dOut     <= w_isZero ? '0 : r_word;
                        r_shAmt    <= w_isZero ? '0 : r_amt;
                        r_zero     <= w_isZero;
                    end else if (OUT_READY) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BARREL_NORMALIZER_CHECK_EN
    logic [DATA_W-1:0]        r_dIn;
    logic                     r_chkErr;
    logic signed [DATA_W-1:0] w_arith;
    logic [DATA_W-1:0]        w_unshift;

    assign w_arith   = $signed(r_word) >>> r_amt;
    assign w_unshift = r_sgn ? w_arith : (r_word >> r_amt);

    // Undo the shift independently of the search and compare with the captured input.
    always_ff @(posedge Clk_s) begin
        if (!Rst_n) begin
            r_dIn    <= '0;
            r_chkErr <= 1'b0;
        end else begin
            if (r_state == IDLE && IN_VALID) begin
                r_dIn <= D_IN;
            end
            if (r_state == DONE && !r_outValid) begin
                r_chkErr <= !w_isZero && (w_unshift != r_dIn);
            end
        end
    end

    assign CHK_ERR = r_chkErr;
`endif

    assign IN_READY  = r_inReady;
    assign OUT_VALID = r_outValid;
    assign D_OUT     = r_dOut;
    assign SH_AMT    = r_shAmt;
    assign ZERO      = r_zero;

endmodule

// File: tb/tb_barrel_normalizer.sv
// Self-checking bench for barrel_normalizer: vector table, scoreboard queue and handshake corner cases.
module tb_barrel_normalizer;

    logic        Clk_s;
    logic        Rst_n;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SGN;
    logic [31:0] D_IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] D_OUT;
    logic [4:0]  SH_AMT;
    logic        ZERO;
`ifdef BARREL_NORMALIZER_CHECK_EN
    logic        CHK_ERR;
`endif

    typedef struct {
        logic [31:0] din;
        logic        sgn;
        logic [31:0] expDout;
        logic [31:0] expAmt;
        logic        expZero;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] amt;
        logic        zero;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   passed = 0;

    barrel_normalizer dut (
        .Clk_s     (Clk_s),
        .Rst_n     (Rst_n),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SGN       (SGN),
        .D_IN      (D_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .D_OUT     (D_OUT),
        .SH_AMT    (SH_AMT),
        .ZERO      (ZERO)
`ifdef BARREL_NORMALIZER_CHECK_EN
        ,
        .CHK_ERR   (CHK_ERR)
`endif
    );

    initial Clk_s = 1'b0;
    always #5 Clk_s = ~Clk_s;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one input word; the expected result joins the scoreboard on the accept edge.
    task automatic applyStimulus(input logic [31:0] din, input logic sgn,
                                 input logic [31:0] expDout, input logic [31:0] expAmt,
                                 input logic expZero);
        exp_t e;
        IN_VALID = 1'b1;
        D_IN     = din;
        SGN      = sgn;
        @(posedge Clk_s);
        e.dout = expDout;
        e.amt  = expAmt;
        e.zero = expZero;
        sbQ.push_back(e);
        @(negedge Clk_s);
        IN_VALID = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s_sb: result 0x%08h with empty scoreboard, expected a queued entry", name, D_OUT);
            return;
        end
        e = sbQ.pop_front();
        checkValue({name, "_dout"}, D_OUT, e.dout);
        checkValue({name, "_amt"}, 32'(SH_AMT), e.amt);
        checkValue({name, "_zero"}, 32'(ZERO), 32'(e.zero));
`ifdef BARREL_NORMALIZER_CHECK_EN
        checkValue({name, "_chk"}, 32'(CHK_ERR), 32'd0);
`endif
    endtask

    // Called at the negedge right after the accept edge; counts edges until OUT_VALID.
    task automatic waitResult(input string name, output bit ok);
        int lat = 0;
        ok = 1'b1;
        while (OUT_VALID !== 1'b1 && lat < 20) begin
            @(posedge Clk_s);
            @(negedge Clk_s);
            lat++;
        end
        if (OUT_VALID !== 1'b1) begin
            checks++;
            $display("[TB] FAIL %s_timeout: OUT_VALID low after %0d edges, expected high after 6", name, lat);
            if (sbQ.size() > 0) sbQ.delete(0);
            ok = 1'b0;
            return;
        end
        checkValue({name, "_lat"}, 32'(lat), 32'd6);
        checkOutput(name);
    endtask

    task automatic collectResult(input string name);
        bit ok;
        waitResult(name, ok);
        if (ok) begin
            OUT_READY = 1'b1;
            @(posedge Clk_s);
            @(negedge Clk_s);
            OUT_READY = 1'b0;
        end
    endtask

    initial begin
        vec_t vecs[12];
        bit   ok;

        vecs[0]  = '{32'h00000001, 1'b0, 32'h80000000, 32'd31, 1'b0};
        vecs[1]  = '{32'h00000001, 1'b1, 32'h40000000, 32'd30, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd31, 1'b0};
        vecs[3]  = '{32'h80000000, 1'b1, 32'h80000000, 32'd0,  1'b0};
        vecs[4]  = '{32'h40000000, 1'b0, 32'h80000000, 32'd1,  1'b0};
        vecs[5]  = '{32'h00000000, 1'b1, 32'h00000000, 32'd0,  1'b1};
        vecs[6]  = '{32'h00000000, 1'b0, 32'h00000000, 32'd0,  1'b1};
        vecs[7]  = '{32'h80000000, 1'b0, 32'h80000000, 32'd0,  1'b0};
        vecs[8]  = '{32'h40000000, 1'b1, 32'h40000000, 32'd0,  1'b0};
        vecs[9]  = '{32'h00012345, 1'b0, 32'h91A28000, 32'd15, 1'b0};
        vecs[10] = '{32'hFFFF8765, 1'b1, 32'h87650000, 32'd16, 1'b0};
        vecs[11] = '{32'h00000003, 1'b1, 32'h60000000, 32'd29, 1'b0};

        Rst_n     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        SGN       = 1'b0;
        D_IN      = '0;

        repeat (2) @(posedge Clk_s);
        @(negedge Clk_s);
        checkValue("reset_in_ready", 32'(IN_READY), 32'd1);
        checkValue("reset_out_valid", 32'(OUT_VALID), 32'd0);
        checkValue("reset_dout", D_OUT, 32'd0);
        checkValue("reset_amt", 32'(SH_AMT), 32'd0);
        checkValue("reset_zero", 32'(ZERO), 32'd0);
`ifdef BARREL_NORMALIZER_CHECK_EN
        checkValue("reset_chk", 32'(CHK_ERR), 32'd0);
`endif
        Rst_n = 1'b1;
        @(negedge Clk_s);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].din, vecs[i].sgn, vecs[i].expDout, vecs[i].expAmt, vecs[i].expZero);
            collectResult($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and no new input may slip in while OUT_READY is low.
        applyStimulus(32'h00000001, 1'b0, 32'h80000000, 32'd31, 1'b0);
        waitResult("bp", ok);
        IN_VALID = 1'b1;
        D_IN     = 32'h40000000;
        SGN      = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk_s);
            @(negedge Clk_s);
            checkValue($sformatf("bp_in_ready%0d", c), 32'(IN_READY), 32'd0);
            checkValue($sformatf("bp_valid%0d", c), 32'(OUT_VALID), 32'd1);
            checkValue($sformatf("bp_dout%0d", c), D_OUT, 32'h80000000);
            checkValue($sformatf("bp_amt%0d", c), 32'(SH_AMT), 32'd31);
        end
        OUT_READY = 1'b1;
        @(posedge Clk_s);
        @(negedge Clk_s);
        OUT_READY = 1'b0;
        checkValue("bp_release_valid", 32'(OUT_VALID), 32'd0);
        checkValue("bp_release_in_ready", 32'(IN_READY), 32'd1);
        checkValue("bp_hold_dout", D_OUT, 32'h80000000);
        checkValue("bp_hold_amt", 32'(SH_AMT), 32'd31);
        applyStimulus(32'h40000000, 1'b0, 32'h80000000, 32'd1, 1'b0);
        collectResult("bp_next");

        // Reset during the third search cycle discards the operation.
        IN_VALID = 1'b1;
        D_IN     = 32'h00000100;
        SGN      = 1'b0;
        @(posedge Clk_s);
        @(negedge Clk_s);
        IN_VALID = 1'b0;
        repeat (2) begin
            @(posedge Clk_s);
            @(negedge Clk_s);
        end
        Rst_n = 1'b0;
        @(posedge Clk_s);
        @(negedge Clk_s);
        Rst_n = 1'b1;
        checkValue("rst_in_ready", 32'(IN_READY), 32'd1);
        checkValue("rst_out_valid", 32'(OUT_VALID), 32'd0);
        checkValue("rst_dout", D_OUT, 32'd0);
        checkValue("rst_amt", 32'(SH_AMT), 32'd0);
        checkValue("rst_zero", 32'(ZERO), 32'd0);
        repeat (8) begin
            @(posedge Clk_s);
            @(negedge Clk_s);
        end
        checkValue("rst_no_partial", 32'(OUT_VALID), 32'd0);
        applyStimulus(32'h00010000, 1'b0, 32'h80000000, 32'd15, 1'b0);
        collectResult("rst_next");

        for (int i = 0; i < 32; i++) begin
            applyStimulus(32'h1 << i, 1'b0, 32'h80000000, 32'(31 - i), 1'b0);
            collectResult($sformatf("sweep_u%0d", i));
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                applyStimulus(32'h1 << i, 1'b1, 32'h80000000, 32'd0, 1'b0);
            end else begin
                applyStimulus(32'h1 << i, 1'b1, 32'h40000000, 32'(30 - i), 1'b0);
            end
            collectResult($sformatf("sweep_s%0d", i));
        end

        checkValue("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/barrel_normalizer.md
Name: barrel_normalizer

Overview:
- Multi-cycle normalizer: left-shifts a 32-bit word until it is normalized and reports the shift distance.
- Inverse of the Barrel_Shifter datapath: the shifter maps (data, amount) to a result; this block recovers the amount from the data.
- Feeds exponent/scale logic in the datapath.
- Valid/ready handshake on both sides; log-step search with one stage per clock.

Parameters:
- DATA_W, 32, data width; must be a power of two ≥ 4.
- AMT_W, $clog2(DATA_W), width of SH_AMT; derived, never overridden.

Ports:
- Clk_s  in  1  clock; all state changes on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- IN_VALID  in  1  D_IN/SGN valid
- IN_READY  out  1  block can accept input
- SGN  in  1  0 = unsigned normalize, 1 = signed (two's complement) normalize
- D_IN  in  DATA_W  word to normalize
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- D_OUT  out  DATA_W  normalized word
- SH_AMT  out  AMT_W  left-shift distance applied
- ZERO  out  1  input was all zeros

Behaviour:
- Reset: Rst_n sampled low at a rising edge of Clk_s gives:
  - state IDLE
  - IN_READY=1, OUT_VALID=0
  - D_OUT=0, SH_AMT=0, ZERO=0
  - Reset mid-operation discards the operation; no partial result is presented.
- States: IDLE → SEARCH → DONE → IDLE.
- IDLE:
  - IN_READY=1.
  - On an edge with IN_VALID=1, D_IN and SGN are captured and the state moves to SEARCH with stage k=AMT_W-1.
- SEARCH: one stage per edge, k = AMT_W-1 down to 0, step s = 2^k.
  - Unsigned: if the top s bits of the working word are all 0, shift left by s and add s to the amount.
  - Signed: if the top s+1 bits are all equal, shift left by s and add s to the amount.
  - Shift-in is always zero.
  - After stage 0 the state moves to DONE.
- Latency: OUT_VALID rises exactly AMT_W+1 edges after the accept edge (6 for DATA_W=32). Latency is fixed and independent of the data.
- DONE:
  - OUT_VALID=1; D_OUT, SH_AMT, ZERO hold stable while OUT_READY=0.
  - On an edge with OUT_READY=1, OUT_VALID falls, the state returns to IDLE, and the data outputs hold their last values.
- IN_READY=0 in SEARCH and DONE. There is no overlap: a new input is never accepted on the same edge a result is taken.
- Zero input (both modes): D_OUT=0, SH_AMT=0, ZERO=1. This overrides the raw search amount.
- Signed all-ones (-1): D_OUT=0x80000000, SH_AMT=DATA_W-1, ZERO=0.
- Already-normalized input (unsigned bit31=1, or signed bit31≠bit30): D_OUT=D_IN, SH_AMT=0.
- Guarantee: D_IN == (D_OUT >> SH_AMT). Logical shift for unsigned, arithmetic for signed; holds for every non-zero input.

Optional Feature:
- Macro: BARREL_NORMALIZER_CHECK_EN.
- Defined:
  - Adds output CHK_ERR (1 bit), registered and valid with OUT_VALID.
  - CHK_ERR=1 if the D_IN guarantee above fails for a non-zero input.
  - The reverse shift is implemented locally.
  - CHK_ERR resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package barrel_pkg holds:
  - DATA_W default
  - state enum (IDLE, SEARCH, DONE)
  - stage step constants.
- One sub-module, norm_step: a combinational single search stage.
  - Inputs: word, SGN, step.
  - Outputs: shifted word, take flag.
  - Used once and selected by stage counter k (iterative, not unrolled).

Test Plan:
- Unsigned D_IN=0x00000001 → D_OUT=0x80000000, SH_AMT=31, ZERO=0; OUT_VALID exactly 6 edges after accept.
- Signed D_IN=0x00000001 → D_OUT=0x40000000, SH_AMT=30. Signed 0xFFFFFFFF → 0x80000000, SH_AMT=31. Signed 0x80000000 → unchanged, SH_AMT=0.
- Unsigned 0x40000000 → 0x80000000, SH_AMT=1. Signed 0x00000000 → D_OUT=0, SH_AMT=0, ZERO=1.
- Backpressure: hold OUT_READY=0 for 3 edges after OUT_VALID while driving IN_VALID=1 with new data.
  - Outputs stay stable and IN_READY=0.
  - New data is not accepted until the edge after the handshake.
- Reset: assert Rst_n=0 in the 3rd SEARCH cycle.
  - Next edge: IN_READY=1, OUT_VALID=0, outputs 0.
  - The following op, 0x00010000 unsigned, gives SH_AMT=15 and D_OUT=0x80000000.
- Sweep 1<<i for i=0..31, unsigned then signed.
  - Unsigned: SH_AMT=31-i.
  - Signed: SH_AMT=30-i for i≤30; i=31 gives SH_AMT=0.
  - With BARREL_NORMALIZER_CHECK_EN defined, CHK_ERR=0 throughout.
